// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers used by the cipher core and its round.
// Holds the FSM state enum, round-count derivation and S-box functions.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } aes_state_e;

    function automatic int aes_nr(input int key_bits);
        return key_bits / 32 + 6;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse; 0 maps to 0 naturally
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3)
                 ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

endpackage

// File: rtl/aes_cipher_core_round.sv
// One combinational AES round, forward or inverse, with optional final-round skip.
// The inverse path exists only when AES_CIPHER_DECRYPT_EN is defined.
module aes_round
    import aes_pkg::*;
(
    input  logic [127:0] state,
    input  logic [127:0] subkey,
    input  logic         inverse,
    input  logic         last,
    output logic [127:0] next_state
);

    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    logic [127:0] sr_sb;
    logic [127:0] mixed;
    logic [127:0] fwd;

    // forward: ShiftRows+SubBytes, MixColumns unless last, AddRoundKey
    always_comb begin
        sr_sb = '0;
        mixed = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr_sb[127 - 8 * (4 * c + r) -: 8] =
                    sbox(state[127 - 8 * (4 * ((c + r) % 4) + r) -: 8]);
            end
        end
        for (int c = 0; c < 4; c++) begin
            mixed[127 - 32 * c -: 32] = mix_col(sr_sb[127 - 32 * c -: 32]);
        end
        fwd = (last ? sr_sb : mixed) ^ subkey;
    end

`ifdef AES_CIPHER_DECRYPT_EN
    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {gf_mul(a0, 8'd14) ^ gf_mul(a1, 8'd11)
                  ^ gf_mul(a2, 8'd13) ^ gf_mul(a3, 8'd9),
                gf_mul(a0, 8'd9) ^ gf_mul(a1, 8'd14)
                  ^ gf_mul(a2, 8'd11) ^ gf_mul(a3, 8'd13),
                gf_mul(a0, 8'd13) ^ gf_mul(a1, 8'd9)
                  ^ gf_mul(a2, 8'd14) ^ gf_mul(a3, 8'd11),
                gf_mul(a0, 8'd11) ^ gf_mul(a1, 8'd13)
                  ^ gf_mul(a2, 8'd9) ^ gf_mul(a3, 8'd14)};
    endfunction

    logic [127:0] isr_isb;
    logic [127:0] keyed;
    logic [127:0] inv;

    // inverse: InvShiftRows+InvSubBytes, AddRoundKey, InvMixColumns unless last
    always_comb begin
        isr_isb = '0;
        inv     = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isr_isb[127 - 8 * (4 * c + r) -: 8] =
                    inv_sbox(state[127 - 8 * (4 * ((c - r + 4) % 4) + r) -: 8]);
            end
        end
        keyed = isr_isb ^ subkey;
        for (int c = 0; c < 4; c++) begin
            inv[127 - 32 * c -: 32] = inv_mix_col(keyed[127 - 32 * c -: 32]);
        end
        if (last) inv = keyed;
    end

    assign next_state = inverse ? inv : fwd;
`else
    logic unused_inverse;
    assign unused_inverse = inverse;
    assign next_state     = fwd;
`endif

endmodule

// File: rtl/aes_cipher_core.sv
// Iterative AES cipher: one round per cycle, round keys fetched from an external store.
// Define AES_CIPHER_DECRYPT_EN to build in the inverse cipher and honour decrypt.
module aes_cipher_core
    import aes_pkg::*;
#(
    parameter int KEY_BITS = 128
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] data_in,
    input  logic         decrypt,
    output logic [3:0]   subkey_addr,
    input  logic [127:0] subkey,
    input  logic         subkey_valid,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy
);

    localparam int NR = aes_nr(KEY_BITS);
    localparam logic [3:0] NR4 = 4'(NR);

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key
        $error("aes_cipher_core: KEY_BITS must be 128, 192 or 256");
    end

    aes_state_e   state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] data_q, data_d;
    logic         dec_q, dec_d;
    logic         dec_in;
    logic [127:0] round_out;

`ifdef AES_CIPHER_DECRYPT_EN
    assign dec_in = decrypt;
`else
    logic unused_decrypt;
    assign unused_decrypt = decrypt;
    assign dec_in         = 1'b0;
`endif

    aes_round u_round (
        .state      (data_q),
        .subkey     (subkey),
        .inverse    (dec_q),
        .last       (round_q == NR4),
        .next_state (round_out)
    );

    // state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            round_q <= '0;
            data_q  <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            data_q  <= data_d;
            dec_q   <= dec_d;
        end
    end

    // next-state, round sequencing and key address
    always_comb begin
        state_d     = state_q;
        round_d     = round_q;
        data_d      = data_q;
        dec_d       = dec_q;
        subkey_addr = 4'd0;
        unique case (state_q)
            IDLE: begin
                subkey_addr = dec_in ? NR4 : 4'd0;
                if (in_valid && subkey_valid) begin
                    data_d  = data_in ^ subkey;
                    round_d = 4'd1;
                    dec_d   = dec_in;
                    state_d = ROUND;
                end
            end
            ROUND: begin
                subkey_addr = dec_q ? NR4 - round_q : round_q;
                if (subkey_valid) begin
                    data_d  = round_out;
                    round_d = round_q + 4'd1;
                    if (round_q == NR4) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                    round_d = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == ROUND) || (state_q == DONE);
    assign data_out  = data_q;

endmodule

// File: tb/tb_aes_cipher_core.sv
// Directed bench for aes_cipher_core at all three key sizes in parallel.
// Round keys come from a bench-side key expansion; expected blocks are FIPS-197 vectors.
module tb_aes_cipher_core;

    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT192 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam int NCYC = 22;
    localparam int NONE = 100;
`ifdef AES_CIPHER_DECRYPT_EN
    localparam bit DEC = 1'b1;
`else
    localparam bit DEC = 1'b0;
`endif

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic               subkey_valid;
    logic               out_ready;
    logic               decrypt;
    logic [127:0]       data_in;
    logic [2:0]         ir, ov, bz;
    logic [2:0][3:0]    addr;
    logic [2:0][127:0]  sk, dout;
    logic [127:0]       rk [3][16];

    int checks = 0;
    int errors = 0;

    int           fv [3];
    logic [127:0] fd [3];
    logic [3:0]   a_seq  [0:NCYC];
    logic         ov_seq [0:NCYC];
    logic         ir_seq [0:NCYC];
    logic         bz_seq [0:NCYC];
    logic [127:0] do_seq [0:NCYC];

    genvar k;
    for (k = 0; k < 3; k++) begin : g_dut
        assign sk[k] = rk[k][addr[k]];
        aes_cipher_core #(.KEY_BITS(128 + 64 * k)) dut (
            .clk          (clk),
            .reset        (reset),
            .in_valid     (in_valid),
            .in_ready     (ir[k]),
            .data_in      (data_in),
            .decrypt      (decrypt),
            .subkey_addr  (addr[k]),
            .subkey       (sk[k]),
            .subkey_valid (subkey_valid),
            .out_valid    (ov[k]),
            .out_ready    (out_ready),
            .data_out     (dout[k]),
            .busy         (bz[k])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    task automatic expand(input int idx);
        int nk, nr;
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        nk = 4 + 2 * idx;
        nr = nk + 6;
        for (int i = 0; i < nk; i++)
            w[i] = {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2), 8'(4 * i + 3)};
        rc = 8'h01;
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[idx][r] = '0;
        for (int r = 0; r <= nr; r++)
            rk[idx][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic check(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rec(input int c);
        a_seq[c]  = addr[0];
        ov_seq[c] = ov[0];
        ir_seq[c] = ir[0];
        bz_seq[c] = bz[0];
        do_seq[c] = dout[0];
        for (int j = 0; j < 3; j++) begin
            if (ov[j] && fv[j] == 0) begin
                fv[j] = c;
                fd[j] = dout[j];
            end
        end
    endtask

    // cycle 0 offers the block; stall/hold/reset are keyed to cycle numbers
    task automatic run(input logic [127:0] din, input logic dec,
                       input int stall_at, input int hold_to, input int rst_at);
        for (int j = 0; j < 3; j++) begin
            fv[j] = 0;
            fd[j] = '0;
        end
        @(posedge clk); #1;
        data_in      = din;
        decrypt      = dec;
        in_valid     = 1'b1;
        subkey_valid = 1'b1;
        out_ready    = (hold_to == 0);
        @(negedge clk);
        rec(0);
        for (int c = 1; c <= NCYC; c++) begin
            @(posedge clk); #1;
            in_valid     = 1'b0;
            subkey_valid = !(c >= stall_at && c < stall_at + 3);
            out_ready    = (c >= hold_to);
            reset        = (c == rst_at);
            @(negedge clk);
            rec(c);
        end
        reset = 1'b0;
    endtask

    logic ok;

    initial begin
        reset = 1'b1; in_valid = 1'b0; subkey_valid = 1'b0;
        out_ready = 1'b1; decrypt = 1'b0; data_in = '0;
        for (int j = 0; j < 3; j++) expand(j);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 128'(ir), 128'h7);
        check("rst_out_valid", 128'(ov), 128'h0);
        check("rst_busy", 128'(bz), 128'h0);
        check("rst_data_out", dout[0] | dout[1] | dout[2], '0);
        check("rst_addr", 128'(addr), 128'h0);

        // offered block but key store not ready: no accept
        @(posedge clk); #1;
        in_valid = 1'b1; data_in = PT;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("nokey_in_ready", 128'(ir), 128'h7);
        check("nokey_busy", 128'(bz), 128'h0);
        #1 in_valid = 1'b0; decrypt = 1'b1;
        #1;
        check("idle_addr_dec128", 128'(addr[0]), DEC ? 128'd10 : 128'd0);
        check("idle_addr_dec256", 128'(addr[2]), DEC ? 128'd14 : 128'd0);
        decrypt = 1'b0;

        // plain encryption at all key sizes
        run(PT, 1'b0, NONE, 0, NONE);
        check("enc128_data", fd[0], CT128);
        check("enc192_data", fd[1], CT192);
        check("enc256_data", fd[2], CT256);
        check("enc128_cycle", 128'(fv[0]), 128'd11);
        check("enc192_cycle", 128'(fv[1]), 128'd13);
        check("enc256_cycle", 128'(fv[2]), 128'd15);
        check("enc_busy_c1", 128'(bz_seq[1]), 128'd1);
        check("enc_ready_c1", 128'(ir_seq[1]), 128'd0);
        check("enc_ov_c12", 128'(ov_seq[12]), 128'd0);
        check("enc_ready_c12", 128'(ir_seq[12]), 128'd1);
        ok = 1'b1;
        for (int c = 1; c <= 10; c++) if (a_seq[c] !== 4'(c)) ok = 1'b0;
        check("enc_addr_seq", 128'(ok), 128'd1);

        // key store stalls for cycles 5..7 while round 5 is pending
        run(PT, 1'b0, 5, 0, NONE);
        check("stall128_data", fd[0], CT128);
        check("stall256_data", fd[2], CT256);
        check("stall128_cycle", 128'(fv[0]), 128'd14);
        check("stall192_cycle", 128'(fv[1]), 128'd16);
        check("stall256_cycle", 128'(fv[2]), 128'd18);
        ok = 1'b1;
        for (int c = 5; c <= 8; c++) if (a_seq[c] !== 4'd5) ok = 1'b0;
        if (a_seq[9] !== 4'd6) ok = 1'b0;
        check("stall_addr_frozen", 128'(ok), 128'd1);

        // consumer back-pressure: out_ready low until cycle 15
        run(PT, 1'b0, NONE, 15, NONE);
        ok = 1'b1;
        for (int c = 11; c <= 15; c++)
            if (ov_seq[c] !== 1'b1 || ir_seq[c] !== 1'b0 || do_seq[c] !== CT128)
                ok = 1'b0;
        check("hold_stable", 128'(ok), 128'd1);
        check("hold_release_ready", 128'(ir_seq[16]), 128'd1);
        check("hold_release_ov", 128'(ov_seq[16]), 128'd0);
        check("hold192_data", fd[1], CT192);

        // reset during round 6 discards the block
        run(PT, 1'b0, NONE, 0, 6);
        check("rst_mid_ready", 128'(ir_seq[7]), 128'd1);
        check("rst_mid_busy", 128'(bz_seq[7]), 128'd0);
        check("rst_mid_data", do_seq[7], '0);
        check("rst_mid_no_ov", 128'(fv[0] + fv[1] + fv[2]), 128'd0);

        run(PT, 1'b0, NONE, 0, NONE);
        check("recover128_data", fd[0], CT128);
        check("recover256_data", fd[2], CT256);
        check("recover128_cycle", 128'(fv[0]), 128'd11);

        // inverse cipher when built in, otherwise decrypt is ignored
        run(DEC ? CT128 : PT, 1'b1, NONE, 0, NONE);
        check("dec128_data", fd[0], DEC ? PT : CT128);
        check("dec128_cycle", 128'(fv[0]), 128'd11);
        ok = 1'b1;
        for (int c = 0; c <= 10; c++)
            if (a_seq[c] !== (DEC ? 4'(10 - c) : 4'(c))) ok = 1'b0;
        check("dec_addr_seq", 128'(ok), 128'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
